passthrough_skid_buffer: RTL

//   Registered, flow-controlled counterpart of the combinational passthrough generator.

---
 rtl/passthrough_skid_buffer.sv | 58 +++++
 1 files changed

// File: rtl/passthrough_skid_buffer.sv
// passthrough_skid_buffer: 2-entry registered ready/valid skid buffer; optional transfer counter under PASSTHROUGH_XFER_COUNT_EN
module passthrough_skid_buffer #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits
`ifdef PASSTHROUGH_XFER_COUNT_EN
  ,
  output logic [31:0]      io_xferCount
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state;
  logic [WIDTH-1:0] main_reg, skid_reg;
  logic in_fire, out_fire;
  assign io_in_ready  = (state != TWO) & ~reset;
  assign io_out_valid = (state != EMPTY);
  assign io_out_bits  = main_reg;
  assign in_fire      = io_in_valid & io_in_ready;
  assign out_fire     = io_out_valid & io_out_ready;
  // occupancy FSM: main feeds the output, skid catches the word accepted while the consumer stalls
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= EMPTY;
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          state    <= ONE;
          main_reg <= io_in_bits;
        end
        ONE: if (in_fire && out_fire) main_reg <= io_in_bits;
          else if (in_fire) begin
            state    <= TWO;
            skid_reg <= io_in_bits;
          end else if (out_fire) state <= EMPTY;
        TWO: if (out_fire) begin
          state    <= ONE;
          main_reg <= skid_reg;
        end
        default: state <= EMPTY;
      endcase
    end
  end
`ifdef PASSTHROUGH_XFER_COUNT_EN
  logic [31:0] xfer_count;
  assign io_xferCount = xfer_count;
  // free-running count of delivered words, wraps at 2^32
  always_ff @(posedge clock) xfer_count <= reset ? 32'd0 : xfer_count + {31'd0, out_fire};
`endif
endmodule
